// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM for a multicycle MIPS-style datapath. Each instruction walks
//   IF -> ID -> (EX) -> (MEM) -> (WB) and returns to IF. Every control output
//   is a combinational decode of the current state, the latched OpCode/Funct
//   and mem_ready. Only the state itself is registered.
//
//   Optional feature: define MEM_WAIT_EN to let IF and MEM stall while
//   mem_ready is low. Without it mem_ready is ignored and each memory phase
//   takes one cycle.
//
// Ports
//   clk, reset (async, active low)      clock / reset
//   OpCode[5:0], Funct[5:0], mem_ready  instruction fields, memory handshake
//   PCWrite PCWriteCond IRWrite RegWrite MemRead MemWrite   write/read strobes
//   IorD ALUSrcA ALUSrcB ALUOp PCSource RegDst MemtoReg ExtOp LuOp  selectors
//   state[2:0], illegal, instr_done     status
//
// Handshake: a memory access in IF or MEM is considered complete in the cycle
// mem_ready is sampled high on the rising edge; the state stays put otherwise.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ExtOp,
  output logic       LuOp,
  output logic [2:0] state,
  output logic       illegal,
  output logic       instr_done
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_mem_ok;
`ifdef MEM_WAIT_EN
  assign w_mem_ok = mem_ready;
`else
  // mem_ready is intentionally ignored in this build.
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = mem_ready;
  assign w_mem_ok = 1'b1;
`endif

  // Instruction class decode
  logic w_r_alu, w_r_shift, w_jr, w_jalr;
  logic w_j, w_jal, w_lw, w_sw, w_beq, w_i_alu, w_i_zext, w_lui, w_legal;

  always_comb begin
    w_r_alu   = 1'b0;
    w_r_shift = 1'b0;
    w_jr      = 1'b0;
    w_jalr    = 1'b0;
    if (OpCode == 6'h00) begin
      case (Funct)
        6'h20, 6'h21, 6'h22, 6'h23,
        6'h24, 6'h25, 6'h26, 6'h27,
        6'h2A, 6'h2B:              w_r_alu   = 1'b1;
        6'h00, 6'h02, 6'h03:       w_r_shift = 1'b1;
        6'h08:                     w_jr      = 1'b1;
        6'h09:                     w_jalr    = 1'b1;
        default:                   w_r_alu   = 1'b0;
      endcase
    end
    w_j      = (OpCode == 6'h02);
    w_jal    = (OpCode == 6'h03);
    w_lw     = (OpCode == 6'h23);
    w_sw     = (OpCode == 6'h2B);
    w_beq    = (OpCode == 6'h04);
    w_i_alu  = (OpCode == 6'h08) || (OpCode == 6'h09) || (OpCode == 6'h0A) ||
               (OpCode == 6'h0B) || (OpCode == 6'h0C) || (OpCode == 6'h0D) ||
               (OpCode == 6'h0F);
    w_i_zext = (OpCode == 6'h0C) || (OpCode == 6'h0D);
    w_lui    = (OpCode == 6'h0F);
    w_legal  = w_r_alu || w_r_shift || w_jr || w_jalr || w_j || w_jal ||
               w_lw || w_sw || w_beq || w_i_alu;
  end

  // Output and next-state decode
  always_comb begin
    w_next      = r_state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    ALUSrcA     = 2'd0;
    ALUSrcB     = 2'd0;
    ALUOp       = 2'd0;
    PCSource    = 2'd0;
    RegDst      = 2'd0;
    MemtoReg    = 2'd0;
    ExtOp       = 1'b0;
    LuOp        = 1'b0;
    illegal     = 1'b0;
    instr_done  = 1'b0;

    case (r_state)
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        if (w_mem_ok) begin
          PCWrite = 1'b1;
          IRWrite = 1'b1;
          w_next  = S_ID;
        end
      end
      S_ID: begin
        // PC + (ImmExt<<2) is latched into ALUOut for a possible beq.
        ALUSrcB = 2'd3;
        if (w_j || w_jal) begin
          PCWrite  = 1'b1;
          PCSource = 2'd2;
          w_next   = S_IF;
          if (w_jal) begin
            RegWrite = 1'b1;
            RegDst   = 2'd2;
            MemtoReg = 2'd2;
          end
        end else if (w_jr || w_jalr) begin
          PCWrite  = 1'b1;
          PCSource = 2'd3;
          w_next   = S_IF;
          if (w_jalr) begin
            RegWrite = 1'b1;
            RegDst   = 2'd1;
            MemtoReg = 2'd2;
          end
        end else if (w_legal) begin
          w_next = S_EX;
        end else begin
          illegal = 1'b1;
          w_next  = S_IF;
        end
      end
      S_EX: begin
        if (w_r_alu || w_r_shift) begin
          ALUSrcA = w_r_shift ? 2'd2 : 2'd1;
          ALUOp   = 2'd2;
          w_next  = S_WB;
        end else if (w_i_alu) begin
          ALUSrcA = 2'd1;
          ALUSrcB = 2'd2;
          ALUOp   = 2'd3;
          ExtOp   = !w_i_zext;
          LuOp    = w_lui;
          w_next  = S_WB;
        end else if (w_lw || w_sw) begin
          ALUSrcA = 2'd1;
          ALUSrcB = 2'd2;
          ExtOp   = 1'b1;
          w_next  = S_MEM;
        end else if (w_beq) begin
          ALUSrcA     = 2'd1;
          ALUOp       = 2'd1;
          PCWriteCond = 1'b1;
          PCSource    = 2'd1;
          w_next      = S_IF;
        end else begin
          illegal = 1'b1;
          w_next  = S_IF;
        end
      end
      S_MEM: begin
        if (w_lw || w_sw) begin
          IorD     = 1'b1;
          MemRead  = w_lw;
          MemWrite = w_sw;
          if (w_mem_ok) w_next = w_lw ? S_WB : S_IF;
        end else begin
          illegal = 1'b1;
          w_next  = S_IF;
        end
      end
      S_WB: begin
        w_next = S_IF;
        if (w_lw) begin
          RegWrite = 1'b1;
          MemtoReg = 2'd1;
        end else if (w_r_alu || w_r_shift) begin
          RegWrite = 1'b1;
          RegDst   = 2'd1;
        end else if (w_i_alu) begin
          RegWrite = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      default: begin
        // Unused encodings 5..7 recover to fetch.
        illegal = 1'b1;
        w_next  = S_IF;
      end
    endcase

    instr_done = ((r_state == S_ID) || (r_state == S_EX) ||
                  (r_state == S_MEM) || (r_state == S_WB)) && (w_next == S_IF);

    // Reset must silence everything immediately, not on the next edge.
    if (!reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IorD        = 1'b0;
      ALUSrcA     = 2'd0;
      ALUSrcB     = 2'd0;
      ALUOp       = 2'd0;
      PCSource    = 2'd0;
      RegDst      = 2'd0;
      MemtoReg    = 2'd0;
      ExtOp       = 1'b0;
      LuOp        = 1'b0;
      illegal     = 1'b0;
      instr_done  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IF;
    else        r_state <= w_next;
  end

  assign state = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller. The reference model expands each
// instruction into its list of expected per-cycle output vectors from the
// instruction class and memory wait counts; a negedge compare process checks
// the DUT against that list. Directed cases pin the model with literal state
// sequences and strobe counts.
module tb_multicycle_controller;

`ifdef MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OpCode, Funct;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite, IorD;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, PCSource, RegDst, MemtoReg;
  logic       ExtOp, LuOp, illegal, instr_done;
  logic [2:0] state;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ExtOp(ExtOp), .LuOp(LuOp),
    .state(state), .illegal(illegal), .instr_done(instr_done)
  );

  // ---------------- model types ----------------
  typedef struct packed {
    logic [2:0] state;
    logic       pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write, iord;
    logic [1:0] alu_src_a, alu_src_b, alu_op, pc_source, reg_dst, mem_to_reg;
    logic       ext_op, lu_op, illegal, instr_done;
  } ov_t;

  typedef enum {C_RALU, C_SHIFT, C_JR, C_JALR, C_J, C_JAL,
                C_LW, C_SW, C_BEQ, C_IALU, C_ILL} cls_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    cls_t       cls;
    bit         ext;
    bit         lu;
  } ins_t;

  logic [25:0] act_v;
  assign act_v = {state, PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite, IorD,
                  ALUSrcA, ALUSrcB, ALUOp, PCSource, RegDst, MemtoReg,
                  ExtOp, LuOp, illegal, instr_done};

  // ---------------- scoreboard ----------------
  logic [25:0] exp_q[$];
  logic [25:0] mask_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  ov_t m_full, m_rst;
  logic [63:0] obs_states;
  int obs_len, obs_regwrite, obs_done, obs_pcwc, obs_illegal, obs_memwrite, obs_memrd_iord;

  task automatic obs_clear();
    obs_states = '0; obs_len = 0; obs_regwrite = 0; obs_done = 0;
    obs_pcwc = 0; obs_illegal = 0; obs_memwrite = 0; obs_memrd_iord = 0;
  endtask

  always @(negedge clk) begin
    logic [25:0] e, m;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      m = mask_q.pop_front();
      n_tests++;
      if (((act_v ^ e) & m) != '0) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t act=%h exp=%h mask=%h op=%h fn=%h",
                 $time, act_v, e, m, OpCode, Funct);
      end
      obs_states     = {obs_states[59:0], 1'b0, state};
      obs_len        = obs_len + 1;
      obs_regwrite   = obs_regwrite + int'(RegWrite);
      obs_done       = obs_done + int'(instr_done);
      obs_pcwc       = obs_pcwc + int'(PCWriteCond);
      obs_illegal    = obs_illegal + int'(illegal);
      obs_memwrite   = obs_memwrite + int'(MemWrite);
      obs_memrd_iord = obs_memrd_iord + int'(MemRead && IorD);
    end
  end

  task automatic check_lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic ins_t mk(input logic [5:0] op, input logic [5:0] fn,
                              input cls_t c, input bit e, input bit l);
    ins_t t;
    t.op = op; t.fn = fn; t.cls = c; t.ext = e; t.lu = l;
    return t;
  endfunction

  function automatic ov_t v_if(input bit rdy);
    ov_t v = '0;
    v.mem_read  = 1'b1;
    v.alu_src_b = 2'd1;
    v.pc_write  = rdy;
    v.ir_write  = rdy;
    return v;
  endfunction

  function automatic ov_t v_id(input ins_t ins);
    ov_t v = '0;
    v.state     = 3'd1;
    v.alu_src_b = 2'd3;
    case (ins.cls)
      C_J, C_JAL: begin
        v.pc_write = 1'b1; v.pc_source = 2'd2; v.instr_done = 1'b1;
        if (ins.cls == C_JAL) begin
          v.reg_write = 1'b1; v.reg_dst = 2'd2; v.mem_to_reg = 2'd2;
        end
      end
      C_JR, C_JALR: begin
        v.pc_write = 1'b1; v.pc_source = 2'd3; v.instr_done = 1'b1;
        if (ins.cls == C_JALR) begin
          v.reg_write = 1'b1; v.reg_dst = 2'd1; v.mem_to_reg = 2'd2;
        end
      end
      C_ILL: begin
        v.illegal = 1'b1; v.instr_done = 1'b1;
      end
      default: ;
    endcase
    return v;
  endfunction

  function automatic ov_t v_ex(input ins_t ins);
    ov_t v = '0;
    v.state = 3'd2;
    case (ins.cls)
      C_RALU:  begin v.alu_src_a = 2'd1; v.alu_op = 2'd2; end
      C_SHIFT: begin v.alu_src_a = 2'd2; v.alu_op = 2'd2; end
      C_IALU: begin
        v.alu_src_a = 2'd1; v.alu_src_b = 2'd2; v.alu_op = 2'd3;
        v.ext_op = ins.ext; v.lu_op = ins.lu;
      end
      C_LW, C_SW: begin
        v.alu_src_a = 2'd1; v.alu_src_b = 2'd2; v.ext_op = 1'b1;
      end
      C_BEQ: begin
        v.alu_src_a = 2'd1; v.alu_op = 2'd1; v.pc_write_cond = 1'b1;
        v.pc_source = 2'd1; v.instr_done = 1'b1;
      end
      default: ;
    endcase
    return v;
  endfunction

  function automatic ov_t v_mem(input bit is_lw, input bit last);
    ov_t v = '0;
    v.state      = 3'd3;
    v.iord       = 1'b1;
    v.mem_read   = is_lw;
    v.mem_write  = !is_lw;
    v.instr_done = last && !is_lw;
    return v;
  endfunction

  function automatic ov_t v_wb(input ins_t ins);
    ov_t v = '0;
    v.state      = 3'd4;
    v.reg_write  = 1'b1;
    v.instr_done = 1'b1;
    if (ins.cls == C_LW) v.mem_to_reg = 2'd1;
    if (ins.cls == C_RALU || ins.cls == C_SHIFT) v.reg_dst = 2'd1;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r, input ov_t e, input ov_t m);
    mem_ready = r;
    exp_q.push_back(e);
    mask_q.push_back(m);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Called at posedge+1 with the DUT in IF; returns at posedge+1 back in IF.
  task automatic run_instr(input ins_t ins, input int if_waits, input int mem_waits);
    int n;
    OpCode = ins.op;
    Funct  = (ins.op == 6'h00) ? ins.fn : 6'($urandom_range(0, 63));
    n = WAIT_EN ? if_waits + 1 : 1;
    for (int i = 0; i < n; i++)
      drive((i < if_waits) ? 1'b0 : 1'b1, v_if(i == n - 1), m_full);
    drive(rnd_bit(), v_id(ins), m_full);
    if (ins.cls inside {C_J, C_JAL, C_JR, C_JALR, C_ILL}) return;
    drive(rnd_bit(), v_ex(ins), m_full);
    if (ins.cls == C_BEQ) return;
    if (ins.cls == C_LW || ins.cls == C_SW) begin
      n = WAIT_EN ? mem_waits + 1 : 1;
      for (int i = 0; i < n; i++)
        drive((i < mem_waits) ? 1'b0 : 1'b1, v_mem(ins.cls == C_LW, i == n - 1), m_full);
      if (ins.cls == C_SW) return;
    end
    drive(rnd_bit(), v_wb(ins), m_full);
  endtask

  // ---------------- stimulus ----------------
  ins_t tbl[$];
  ins_t i_add, i_lw, i_sw, i_beq, i_jal, i_bad;

  initial begin
    m_full = '1;
    m_rst  = '0;
    m_rst.state = 3'b111;
    m_rst.pc_write = 1'b1; m_rst.pc_write_cond = 1'b1; m_rst.ir_write = 1'b1;
    m_rst.reg_write = 1'b1; m_rst.mem_read = 1'b1; m_rst.mem_write = 1'b1;
    m_rst.illegal = 1'b1; m_rst.instr_done = 1'b1;

    foreach (tbl[k]) tbl.delete();
    for (int f = 6'h20; f <= 6'h27; f++) tbl.push_back(mk(6'h00, 6'(f), C_RALU, 1'b0, 1'b0));
    tbl.push_back(mk(6'h00, 6'h2A, C_RALU, 1'b0, 1'b0));
    tbl.push_back(mk(6'h00, 6'h2B, C_RALU, 1'b0, 1'b0));
    tbl.push_back(mk(6'h00, 6'h00, C_SHIFT, 1'b0, 1'b0));
    tbl.push_back(mk(6'h00, 6'h02, C_SHIFT, 1'b0, 1'b0));
    tbl.push_back(mk(6'h00, 6'h03, C_SHIFT, 1'b0, 1'b0));
    tbl.push_back(mk(6'h00, 6'h08, C_JR,    1'b0, 1'b0));
    tbl.push_back(mk(6'h00, 6'h09, C_JALR,  1'b0, 1'b0));
    tbl.push_back(mk(6'h00, 6'h01, C_ILL,   1'b0, 1'b0));
    tbl.push_back(mk(6'h00, 6'h18, C_ILL,   1'b0, 1'b0));
    tbl.push_back(mk(6'h00, 6'h3F, C_ILL,   1'b0, 1'b0));
    tbl.push_back(mk(6'h23, 6'h00, C_LW,    1'b0, 1'b0));
    tbl.push_back(mk(6'h2B, 6'h00, C_SW,    1'b0, 1'b0));
    tbl.push_back(mk(6'h04, 6'h00, C_BEQ,   1'b0, 1'b0));
    tbl.push_back(mk(6'h02, 6'h00, C_J,     1'b0, 1'b0));
    tbl.push_back(mk(6'h03, 6'h00, C_JAL,   1'b0, 1'b0));
    tbl.push_back(mk(6'h08, 6'h00, C_IALU,  1'b1, 1'b0));
    tbl.push_back(mk(6'h09, 6'h00, C_IALU,  1'b1, 1'b0));
    tbl.push_back(mk(6'h0A, 6'h00, C_IALU,  1'b1, 1'b0));
    tbl.push_back(mk(6'h0B, 6'h00, C_IALU,  1'b1, 1'b0));
    tbl.push_back(mk(6'h0C, 6'h00, C_IALU,  1'b0, 1'b0));
    tbl.push_back(mk(6'h0D, 6'h00, C_IALU,  1'b0, 1'b0));
    tbl.push_back(mk(6'h0F, 6'h00, C_IALU,  1'b1, 1'b1));
    tbl.push_back(mk(6'h3F, 6'h00, C_ILL,   1'b0, 1'b0));
    tbl.push_back(mk(6'h05, 6'h00, C_ILL,   1'b0, 1'b0));
    tbl.push_back(mk(6'h0E, 6'h00, C_ILL,   1'b0, 1'b0));
    tbl.push_back(mk(6'h20, 6'h00, C_ILL,   1'b0, 1'b0));

    i_add = mk(6'h00, 6'h20, C_RALU, 1'b0, 1'b0);
    i_lw  = mk(6'h23, 6'h00, C_LW,   1'b0, 1'b0);
    i_sw  = mk(6'h2B, 6'h00, C_SW,   1'b0, 1'b0);
    i_beq = mk(6'h04, 6'h00, C_BEQ,  1'b0, 1'b0);
    i_jal = mk(6'h03, 6'h00, C_JAL,  1'b0, 1'b0);
    i_bad = mk(6'h3F, 6'h00, C_ILL,  1'b0, 1'b0);

    // Reset: outputs silent even with mem_ready high.
    reset = 1'b0; mem_ready = 1'b1; OpCode = 6'h00; Funct = 6'h20;
    @(posedge clk); #1;
    check_lit("rst_state", 64'(state), 64'd0);
    check_lit("rst_memread_pcwrite", 64'({MemRead, PCWrite, IRWrite}), 64'd0);
    drive(1'b1, '0, m_rst);
    drive(1'b1, '0, m_rst);
    reset = 1'b1;

    // add $3,$1,$2
    obs_clear();
    run_instr(i_add, 0, 0);
    check_lit("add_states", obs_states, 64'h0124);
    check_lit("add_cycles", 64'(obs_len), 64'd4);
    check_lit("add_regwrite_cnt", 64'(obs_regwrite), 64'd1);
    check_lit("add_done_cnt", 64'(obs_done), 64'd1);

    // lw with two MEM wait cycles
    obs_clear();
    run_instr(i_lw, 0, 2);
    if (WAIT_EN) begin
      check_lit("lw_states", obs_states, 64'h0123334);
      check_lit("lw_cycles", 64'(obs_len), 64'd7);
      check_lit("lw_memrd_iord_cnt", 64'(obs_memrd_iord), 64'd3);
    end else begin
      check_lit("lw_states", obs_states, 64'h01234);
      check_lit("lw_cycles", 64'(obs_len), 64'd5);
      check_lit("lw_memrd_iord_cnt", 64'(obs_memrd_iord), 64'd1);
    end

    // beq
    obs_clear();
    run_instr(i_beq, 0, 0);
    check_lit("beq_states", obs_states, 64'h012);
    check_lit("beq_pcwc_cnt", 64'(obs_pcwc), 64'd1);

    // jal
    obs_clear();
    run_instr(i_jal, 0, 0);
    check_lit("jal_states", obs_states, 64'h01);
    check_lit("jal_regwrite_cnt", 64'(obs_regwrite), 64'd1);

    // OpCode 0x3F
    obs_clear();
    run_instr(i_bad, 0, 0);
    check_lit("ill_states", obs_states, 64'h01);
    check_lit("ill_pulse_cnt", 64'(obs_illegal), 64'd1);
    check_lit("ill_writes", 64'(obs_regwrite + obs_memwrite), 64'd0);

    // Reset dropped during MEM of sw
    OpCode = i_sw.op; Funct = 6'($urandom_range(0, 63));
    drive(1'b1, v_if(1'b1), m_full);
    drive(rnd_bit(), v_id(i_sw), m_full);
    drive(rnd_bit(), v_ex(i_sw), m_full);
    mem_ready = 1'b0;
    #1;
    check_lit("sw_mem_before_rst", 64'({state, MemWrite}), 64'({3'd3, 1'b1}));
    reset = 1'b0;
    #1;
    check_lit("sw_mem_async_rst", 64'({state, MemWrite}), 64'd0);
    exp_q.push_back('0);
    mask_q.push_back(m_rst);
    @(posedge clk); #1;
    drive(1'b1, '0, m_rst);
    reset = 1'b1;
    obs_clear();
    run_instr(i_add, 0, 0);
    check_lit("post_rst_add_states", obs_states, 64'h0124);
    check_lit("post_rst_writes", 64'(obs_regwrite), 64'd1);

    // Random instruction stream with random memory waits
    for (int n = 0; n < 150; n++) begin
      int idx;
      idx = $urandom_range(0, tbl.size() - 1);
      run_instr(tbl[idx], $urandom_range(0, 3), $urandom_range(0, 3));
    end

    check_lit("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
